// File: rtl/scc_run_ctrl.sv
// rtl/scc_run_ctrl.sv - SCC core run controller: core reset sequencing, clock-enable gating, run termination
module scc_run_ctrl #(
   parameter int RST_CYCLES = 3,
   parameter int MAX_CYCLES = 500,
   parameter int CNT_W      = 16,
   parameter int ERR_W      = 2,
   parameter int INSTR_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               step_mode,
   input  logic               step_req,
   input  logic               halt_f,
   input  logic [ERR_W-1:0]   err_bits,
   input  logic               bp_en,
   input  logic [INSTR_W-1:0] bp_value,
   input  logic [INSTR_W-1:0] instr_word,
   output logic               core_rst,
   output logic               core_clk_en,
   output logic [CNT_W-1:0]   cycle_count,
   output logic               busy,
   output logic               done,
   output logic [2:0]         done_cause,
   output logic [ERR_W-1:0]   err_latched
);
   localparam int              RC_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST    = RC_W'(RST_CYCLES - 1);
   localparam logic [CNT_W:0]  MAX_C      = (CNT_W+1)'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
   localparam bit              TIMEOUT_EN = (MAX_CYCLES != 0);

   localparam logic [2:0] CAUSE_NONE    = 3'd0;
   localparam logic [2:0] CAUSE_HALT    = 3'd1;
   localparam logic [2:0] CAUSE_TIMEOUT = 3'd2;
   localparam logic [2:0] CAUSE_ERROR   = 3'd3;
   localparam logic [2:0] CAUSE_BP      = 3'd4;
   localparam logic [2:0] CAUSE_ABORT   = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic              core_rst_q, core_rst_d;
   logic              core_clk_en_q, core_clk_en_d;
   logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [2:0]        done_cause_q, done_cause_d;
   logic [ERR_W-1:0]  err_latched_q, err_latched_d;

   logic [CNT_W:0]    cnt_plus1;
   logic              bp_hit;
   logic              timeout_hit;
   logic [2:0]        end_cause;

   always_comb begin
      cnt_plus1   = {1'b0, cycle_count_q} + {{CNT_W{1'b0}}, 1'b1};
      bp_hit      = bp_en && (instr_word == bp_value);
      timeout_hit = TIMEOUT_EN && core_clk_en_q && (cnt_plus1 == MAX_C);

      // Termination priority: abort > error > halt > breakpoint > timeout
      if (abort)              end_cause = CAUSE_ABORT;
      else if (|err_bits)     end_cause = CAUSE_ERROR;
      else if (halt_f)        end_cause = CAUSE_HALT;
      else if (bp_hit)        end_cause = CAUSE_BP;
      else if (timeout_hit)   end_cause = CAUSE_TIMEOUT;
      else                    end_cause = CAUSE_NONE;

      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      core_rst_d    = core_rst_q;
      core_clk_en_d = core_clk_en_q;
      cycle_count_d = cycle_count_q;
      busy_d        = busy_q;
      done_d        = done_q;
      done_cause_d  = done_cause_q;
      err_latched_d = err_latched_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d       = S_RESET;
               rst_cnt_d     = '0;
               core_rst_d    = 1'b1;
               core_clk_en_d = 1'b1;
               cycle_count_d = '0;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               done_cause_d  = CAUSE_NONE;
               err_latched_d = '0;
            end
         end
         S_RESET: begin
            if (abort) begin
               state_d       = S_DONE;
               core_clk_en_d = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               done_cause_d  = CAUSE_ABORT;
            end else if (rst_cnt_q == RC_LAST) begin
               state_d       = S_RUN;
               core_rst_d    = 1'b0;
               core_clk_en_d = !step_mode;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         S_RUN: begin
            // The edge closing an enabled cycle counts it, including the terminating edge
            if (core_clk_en_q && (cycle_count_q != CNT_SAT))
               cycle_count_d = cnt_plus1[CNT_W-1:0];
            err_latched_d = err_latched_q | err_bits;
            core_clk_en_d = step_mode ? step_req : 1'b1;
            if (end_cause != CAUSE_NONE) begin
               state_d       = S_DONE;
               core_clk_en_d = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               done_cause_d  = end_cause;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rst_cnt_q     <= '0;
         core_rst_q    <= 1'b1;
         core_clk_en_q <= 1'b0;
         cycle_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         done_cause_q  <= CAUSE_NONE;
         err_latched_q <= '0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         core_rst_q    <= core_rst_d;
         core_clk_en_q <= core_clk_en_d;
         cycle_count_q <= cycle_count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         done_cause_q  <= done_cause_d;
         err_latched_q <= err_latched_d;
      end
   end

   assign core_rst    = core_rst_q;
   assign core_clk_en = core_clk_en_q;
   assign cycle_count = cycle_count_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign done_cause  = done_cause_q;
   assign err_latched = err_latched_q;
endmodule

// File: tb/tb_scc_run_ctrl.sv
// tb/tb_scc_run_ctrl.sv - scoreboard bench for scc_run_ctrl
module tb_scc_run_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, abort, step_mode, step_req, halt_f, bp_en;
   logic [1:0]  err_bits;
   logic [31:0] bp_value, instr_word;
   logic        core_rst, core_clk_en, busy, done;
   logic [15:0] cycle_count;
   logic [2:0]  done_cause;
   logic [1:0]  err_latched;

   logic        s_rst, s_start;
   logic        s_core_rst, s_core_clk_en, s_busy, s_done;
   logic [15:0] s_cycle_count;
   logic [2:0]  s_done_cause;
   logic [1:0]  s_err_latched;

   scc_run_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .step_mode(step_mode),
      .step_req(step_req), .halt_f(halt_f), .err_bits(err_bits), .bp_en(bp_en),
      .bp_value(bp_value), .instr_word(instr_word), .core_rst(core_rst),
      .core_clk_en(core_clk_en), .cycle_count(cycle_count), .busy(busy), .done(done),
      .done_cause(done_cause), .err_latched(err_latched)
   );

   scc_run_ctrl #(.MAX_CYCLES(0)) u_sat (
      .clk(clk), .rst(s_rst), .start(s_start), .abort(1'b0), .step_mode(1'b0),
      .step_req(1'b0), .halt_f(1'b0), .err_bits(2'b00), .bp_en(1'b0),
      .bp_value(32'h0), .instr_word(32'h0), .core_rst(s_core_rst),
      .core_clk_en(s_core_clk_en), .cycle_count(s_cycle_count), .busy(s_busy), .done(s_done),
      .done_cause(s_done_cause), .err_latched(s_err_latched)
   );

   int n_cmp = 0;
   int n_fail = 0;
   bit sat_finished = 1'b0;

   typedef struct {
      string      name;
      logic [2:0]  cause;
      logic [15:0] count;
      logic [1:0]  err;
      logic        crst;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input string nm, input logic [2:0] c, input logic [15:0] n,
                           input logic [1:0] e, input logic r);
      exp_t x;
      x.name = nm; x.cause = c; x.count = n; x.err = e; x.crst = r;
      exp_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion monitor: pops one expectation for every rising edge of done
   logic done_seen = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1 && !done_seen) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 cause=%0d expected no completion", done_cause);
         end else begin
            e = exp_q.pop_front();
            check({e.name, "_cause"}, done_cause, e.cause);
            check({e.name, "_count"}, cycle_count, e.count);
            check({e.name, "_err"}, err_latched, e.err);
            check({e.name, "_core_rst"}, core_rst, e.crst);
            check({e.name, "_clk_en"}, core_clk_en, 0);
            check({e.name, "_busy"}, busy, 0);
         end
      end
      done_seen = (done === 1'b1);
   end

   task automatic start_run(input string nm);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, "_start_busy"}, busy, 1);
      check({nm, "_start_core_rst"}, core_rst, 1);
      check({nm, "_start_clk_en"}, core_clk_en, 1);
      check({nm, "_start_done"}, done, 0);
      check({nm, "_start_count"}, cycle_count, 0);
      check({nm, "_start_cause"}, done_cause, 0);
      check({nm, "_start_err"}, err_latched, 0);
   endtask

   task automatic wait_run_entry(input string nm);
      int n = 0;
      while (core_rst !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check({nm, "_reset_len"}, n, 3);
      check({nm, "_entry_clk_en"}, core_clk_en, {31'd0, !step_mode});
   endtask

   task automatic wait_count(input string nm, input logic [15:0] target, input int limit);
      int n = 0;
      while (cycle_count !== target && n < limit) begin
         tick();
         n++;
      end
      check({nm, "_reach_count"}, cycle_count, target);
   endtask

   task automatic wait_done(input string nm, input int limit);
      int n = 0;
      while (done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      check({nm, "_done"}, done, 1);
   endtask

   initial begin
      int n;
      int en_cnt;
      rst = 1'b1; start = 1'b1; abort = 1'b1; step_mode = 1'b0; step_req = 1'b1;
      halt_f = 1'b0; err_bits = 2'b00; bp_en = 1'b0; bp_value = 32'hFC000000; instr_word = 32'h0;
      repeat (3) tick();
      check("rst_core_rst", core_rst, 1);
      check("rst_clk_en", core_clk_en, 0);
      check("rst_count", cycle_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cause", done_cause, 0);
      check("rst_err", err_latched, 0);
      rst = 1'b0; start = 1'b0; step_req = 1'b0;
      tick();
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_done", done, 0);

      // Halt after 20 enabled cycles: the 21st cycle is the terminating one
      push_exp("halt", 3'd1, 16'd21, 2'b00, 1'b0);
      start_run("t1");
      wait_run_entry("t1");
      wait_count("t1", 16'd20, 40);
      halt_f = 1'b1;
      wait_done("t1", 5);
      halt_f = 1'b0;

      // Timeout 500 enabled cycles after RUN entry; a start mid-run must be ignored
      push_exp("timeout", 3'd2, 16'd500, 2'b00, 1'b0);
      start_run("t2");
      wait_run_entry("t2");
      n = 0;
      repeat (5) begin tick(); n++; end
      start = 1'b1;
      tick(); n++;
      start = 1'b0;
      check("t2_busy_after_start", busy, 1);
      while (done !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
      check("t2_timeout_latency", n, 500);
      abort = 1'b1; step_req = 1'b1;
      repeat (3) tick();
      abort = 1'b0; step_req = 1'b0;
      check("t2_hold_done", done, 1);
      check("t2_hold_cause", done_cause, 2);
      check("t2_hold_count", cycle_count, 500);
      check("t2_hold_clk_en", core_clk_en, 0);

      // Single-step: three isolated requests, then a held request
      step_mode = 1'b1;
      start_run("t3");
      wait_run_entry("t3");
      en_cnt = 0;
      for (int p = 0; p < 3; p++) begin
         repeat (2) begin tick(); if (core_clk_en === 1'b1) en_cnt++; end
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         check("t3_step_en", core_clk_en, 1);
         if (core_clk_en === 1'b1) en_cnt++;
      end
      repeat (10) begin tick(); if (core_clk_en === 1'b1) en_cnt++; end
      check("t3_en_pulses", en_cnt, 3);
      check("t3_count", cycle_count, 3);
      check("t3_busy", busy, 1);
      check("t3_not_done", done, 0);
      step_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_held_en", core_clk_en, 1);
      end
      step_req = 1'b0;
      tick();
      check("t3_held_release", core_clk_en, 0);
      check("t3_held_count", cycle_count, 7);
      push_exp("step_abort", 3'd5, 16'd7, 2'b00, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("t3", 3);
      step_mode = 1'b0;

      // Error and halt together: error wins; matching instr with bp_en=0 must not stop the run
      instr_word = 32'hFC000000;
      push_exp("err_halt", 3'd3, 16'd6, 2'b10, 1'b0);
      start_run("t4");
      wait_run_entry("t4");
      repeat (5) tick();
      err_bits = 2'b10; halt_f = 1'b1;
      tick();
      err_bits = 2'b00; halt_f = 1'b0;
      wait_done("t4", 3);

      // Breakpoint: near-miss word until count 12, then exact match
      bp_en = 1'b1;
      instr_word = 32'hFC000001;
      push_exp("bp", 3'd4, 16'd13, 2'b00, 1'b0);
      start_run("t5");
      wait_run_entry("t5");
      wait_count("t5", 16'd12, 30);
      instr_word = 32'hFC000000;
      wait_done("t5", 3);
      bp_en = 1'b0; instr_word = 32'h0;

      // Abort during RESET keeps core_rst high
      push_exp("abort_reset", 3'd5, 16'd0, 2'b00, 1'b1);
      start_run("t6");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("t6", 3);

      // rst mid-RUN, then start+abort together from IDLE
      start_run("t7");
      wait_run_entry("t7");
      wait_count("t7", 16'd40, 60);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t7_rst_core_rst", core_rst, 1);
      check("t7_rst_clk_en", core_clk_en, 0);
      check("t7_rst_count", cycle_count, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_done", done, 0);
      check("t7_rst_cause", done_cause, 0);
      check("t7_rst_err", err_latched, 0);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("t7_start_wins_busy", busy, 1);
      check("t7_start_wins_done", done, 0);
      check("t7_start_wins_core_rst", core_rst, 1);
      wait_run_entry("t7b");
      check("t7_fresh_count", cycle_count, 0);
      push_exp("restart", 3'd1, 16'd4, 2'b00, 1'b0);
      repeat (3) tick();
      halt_f = 1'b1;
      tick();
      halt_f = 1'b0;
      wait_done("t7", 3);

      wait (sat_finished);
      repeat (2) tick();
      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // MAX_CYCLES=0 instance: no timeout, counter saturates at 65535
   initial begin
      s_rst = 1'b1; s_start = 1'b0;
      repeat (2) tick();
      s_rst = 1'b0; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      repeat (600) tick();
      check("sat_count_600", s_cycle_count, 597);
      check("sat_no_timeout", s_done, 0);
      repeat (69400) tick();
      check("sat_count", s_cycle_count, 16'hFFFF);
      check("sat_done", s_done, 0);
      check("sat_busy", s_busy, 1);
      check("sat_cause", s_done_cause, 0);
      sat_finished = 1'b1;
   end
endmodule
